// File: rtl/axi4_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_frame_pkg
// Description : Shared AXI4 constants, the write/read FSM state encodings and
//               a burst-attribute checker for the frame-buffer slave.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_frame_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B     = 3'd3;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    // Only 8-byte INCR bursts are served; anything else is flagged SLVERR.
    function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != AXI_SIZE_8B) || (burst != AXI_BURST_INCR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_frame_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi4_frame_mem
// Description : Dual-port word RAM. Port A writes with byte enables, port B
//               reads through an output register (read-first on a collision).
// Ports       : clk        - clock
//               i_a_we     - byte write enables for port A
//               i_a_addr   - port A word address
//               i_a_wdata  - port A write data
//               i_b_en     - port B read enable (output holds when low)
//               i_b_addr   - port B word address
//               o_b_rdata  - registered port B read data
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_frame_mem #(
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 65536,
    parameter int ADDR_BITS = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic [DATA_W/8-1:0]   i_a_we,
    input  logic [ADDR_BITS-1:0]  i_a_addr,
    input  logic [DATA_W-1:0]     i_a_wdata,
    input  logic                  i_b_en,
    input  logic [ADDR_BITS-1:0]  i_b_addr,
    output logic [DATA_W-1:0]     o_b_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_WORDS];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W/8; i++) begin
            if (i_a_we[i]) begin
                r_mem[i_a_addr][i*8 +: 8] <= i_a_wdata[i*8 +: 8];
            end
        end
    end

    // Holding the register when disabled is what keeps RDATA stable during
    // read back-pressure in the parent.
    always_ff @(posedge clk) begin
        if (i_b_en) begin
            r_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_b_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi4_frame_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi4_frame_slave
// Description : AXI4 slave backed by an internal word memory; stands in for
//               the DDR path so a frame writer and reader can run closed-loop.
//               Independent write (AW/W/B) and read (AR/R) engines, INCR
//               bursts of 64-bit beats, addresses wrap modulo MEM_WORDS.
// Ports       : clk_100Mhz, sys_rst_n (async, active low)
//               AW*/W*/B*  - write address, data and response channels
//               AR*/R*     - read address and data channels
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_frame_slave
    import axi4_frame_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int MEM_WORDS  = 65536,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk_100Mhz,
    input  logic              sys_rst_n,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [7:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic [63:0]       WDATA,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic              WLAST,
    input  logic [7:0]        WSTRB,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        BRESP,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [7:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    output logic [63:0]       RDATA,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              RLAST,
    output logic [1:0]        RRESP
);

    localparam int WA = $clog2(MEM_WORDS);

    // Keeps AWREADY/ARREADY low while in reset and for the first clock after.
    logic r_live;

    // ---------------- write engine ----------------
    wr_state_t      r_wstate, w_wstate_nxt;
    logic [WA-1:0]  r_waddr;
    logic [7:0]     r_wlen, r_wcnt;
    logic           r_werr;
    logic           w_aw_hs, w_w_hs;

    assign w_aw_hs = AWVALID & AWREADY;
    assign w_w_hs  = WVALID & WREADY;

    always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_live   <= 1'b0;
            r_wstate <= W_IDLE;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
        end else begin
            r_live   <= 1'b1;
            r_wstate <= w_wstate_nxt;
            if (w_aw_hs) begin
                r_waddr <= AWADDR[WA+2:3];
                r_wlen  <= AWLEN;
                r_wcnt  <= '0;
                r_werr  <= burst_bad(AWSIZE, AWBURST);
            end
            if (w_w_hs) begin
                r_waddr <= r_waddr + 1'b1;
                r_wcnt  <= r_wcnt + 8'd1;
                if (WLAST != (r_wcnt == r_wlen)) begin
                    r_werr <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        AWREADY      = 1'b0;
        WREADY       = 1'b0;
        BVALID       = 1'b0;
        BRESP        = AXI_RESP_OKAY;
        case (r_wstate)
            W_IDLE: begin
                AWREADY = r_live;
                if (AWVALID && r_live) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                // A missing WLAST still ends the burst after AWLEN+1 beats.
                if (WVALID && (WLAST || (r_wcnt == r_wlen))) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                BRESP  = r_werr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                if (BREADY) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // ---------------- read engine ----------------
    rd_state_t      r_rstate, w_rstate_nxt;
    logic [WA-1:0]  r_raddr;
    logic [7:0]     r_rlen, r_rbeat;
    logic           r_rerr;
    logic [3:0]     r_rwait;
    logic           w_ar_hs, w_rd_en, w_rd_adv;
    logic [WA-1:0]  w_rd_addr;
    logic [63:0]    w_mem_q;

    assign w_ar_hs = ARVALID & ARREADY;

    always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rstate <= R_IDLE;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rbeat  <= '0;
            r_rerr   <= 1'b0;
            r_rwait  <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_raddr <= ARADDR[WA+2:3];
                r_rlen  <= ARLEN;
                r_rbeat <= '0;
                r_rerr  <= burst_bad(ARSIZE, ARBURST);
                r_rwait <= 4'(RD_LATENCY);
            end
            if ((r_rstate == R_WAIT) && (r_rwait != 4'd0)) begin
                r_rwait <= r_rwait - 4'd1;
            end
            if (w_rd_adv) begin
                r_raddr <= r_raddr + 1'b1;
                r_rbeat <= r_rbeat + 8'd1;
            end
        end
    end

    // r_raddr always names the beat being presented. The RAM output register
    // holds that beat; on an accepted beat the next word is fetched in the
    // same cycle so it appears with no bubble, and during a stall the fetch
    // is suppressed so the presented beat stays put.
    always_comb begin
        w_rstate_nxt = r_rstate;
        ARREADY      = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_adv     = 1'b0;
        w_rd_addr    = r_raddr;
        RVALID       = 1'b0;
        RLAST        = 1'b0;
        RRESP        = AXI_RESP_OKAY;
        RDATA        = '0;
        case (r_rstate)
            R_IDLE: begin
                ARREADY = r_live;
                if (ARVALID && r_live) w_rstate_nxt = R_WAIT;
            end
            R_WAIT: begin
                if (r_rwait == 4'd0) begin
                    w_rd_en      = 1'b1;
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                RVALID = 1'b1;
                RLAST  = (r_rbeat == r_rlen);
                RRESP  = r_rerr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                RDATA  = w_mem_q;
                if (RREADY) begin
                    if (r_rbeat == r_rlen) begin
                        w_rstate_nxt = R_IDLE;
                    end else begin
                        w_rd_en   = 1'b1;
                        w_rd_adv  = 1'b1;
                        w_rd_addr = r_raddr + 1'b1;
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    axi4_frame_mem #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_mem (
        .clk       (clk_100Mhz),
        .i_a_we    (w_w_hs ? WSTRB : 8'h00),
        .i_a_addr  (r_waddr),
        .i_a_wdata (WDATA),
        .i_b_en    (w_rd_en),
        .i_b_addr  (w_rd_addr),
        .o_b_rdata (w_mem_q)
    );

    // Address bits above the memory index and the byte offset are ignored.
    logic w_unused;
    assign w_unused = ^{AWADDR, ARADDR};

endmodule
`default_nettype wire

// File: tb/tb_axi4_frame_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_frame_slave
// Description : Self-checking bench for axi4_frame_slave with a 16-word
//               memory; a word-array reference model predicts read data and
//               responses from the bus-level rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_frame_slave;
    import axi4_frame_pkg::*;

    localparam int MEM_WORDS  = 16;
    localparam int RD_LATENCY = 2;
    localparam int NO_LAST    = 999;

    logic        clk_100Mhz = 1'b0;
    logic        sys_rst_n;
    logic [31:0] AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic [7:0]  AWLEN, ARLEN, WSTRB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [63:0] WDATA, RDATA;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] model_mem [MEM_WORDS];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    always #5 clk_100Mhz = ~clk_100Mhz;

    axi4_frame_slave #(
        .ADDR_W(32), .DATA_W(64), .MEM_WORDS(MEM_WORDS), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk_100Mhz(clk_100Mhz), .sys_rst_n(sys_rst_n),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RRESP(RRESP)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100Mhz);
        #1;
    endtask

    task automatic model_write(input int word, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++)
            if (s[b]) model_mem[word % MEM_WORDS][b*8 +: 8] = d[b*8 +: 8];
    endtask

    // Burst of len+1 beats from wd/ws; WLAST on beat last_at (NO_LAST = never).
    task automatic axi_write(input int start_word, input int len, input int last_at,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [1:0] exp_resp, input bit chk_timing);
        int to, n;
        AWADDR  = ($urandom << 7) | 32'(start_word * 8);
        AWLEN   = 8'(len);
        AWSIZE  = size;
        AWBURST = burst;
        AWVALID = 1'b1;
        to = 0;
        while (!AWREADY && to < 20) begin tick(); to++; end
        check("aw_ready", 64'(AWREADY), 64'd1);
        tick();
        AWVALID = 1'b0;
        n = (last_at <= len) ? last_at + 1 : len + 1;
        for (int i = 0; i < n; i++) begin
            WDATA  = wd[i];
            WSTRB  = ws[i];
            WLAST  = (i == last_at);
            WVALID = 1'b1;
            to = 0;
            while (!WREADY && to < 20) begin tick(); to++; end
            if (chk_timing) check("w_back_to_back_wait", 64'(to), 64'd0);
            else            check("w_ready", 64'(WREADY), 64'd1);
            tick();
            model_write(start_word + i, wd[i], ws[i]);
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        if (chk_timing) check("bvalid_after_last", 64'(BVALID), 64'd1);
        BREADY = 1'b1;
        to = 0;
        while (!BVALID && to < 20) begin tick(); to++; end
        check("bvalid", 64'(BVALID), 64'd1);
        check("bresp", 64'(BRESP), 64'(exp_resp));
        tick();
        BREADY = 1'b0;
        check("bvalid_drop", 64'(BVALID), 64'd0);
    endtask

    // rmode: 0 = RREADY always high, 1 = pattern 1,0,0,1, 2 = random.
    task automatic axi_read(input int start_word, input int len, input logic [1:0] burst,
                            input int rmode, input logic [1:0] exp_resp, input bit chk_data);
        logic [63:0] exp [256];
        int to, lat, beat, cyc;
        logic rr;
        for (int i = 0; i <= len; i++) exp[i] = model_mem[(start_word + i) % MEM_WORDS];
        ARADDR  = ($urandom << 7) | 32'(start_word * 8);
        ARLEN   = 8'(len);
        ARSIZE  = AXI_SIZE_8B;
        ARBURST = burst;
        ARVALID = 1'b1;
        RREADY  = 1'b0;
        to = 0;
        while (!ARREADY && to < 20) begin tick(); to++; end
        check("ar_ready", 64'(ARREADY), 64'd1);
        tick();
        ARVALID = 1'b0;
        lat = 0;
        while (!RVALID && lat < 40) begin tick(); lat++; end
        // handshake in cycle N, first RVALID in cycle N+2+RD_LATENCY
        check("r_first_latency", 64'(lat), 64'(RD_LATENCY + 1));
        beat = 0; cyc = 0;
        while (beat <= len && cyc < 300) begin
            case (rmode)
                0:       rr = 1'b1;
                1:       rr = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            RREADY = rr;
            check("rvalid", 64'(RVALID), 64'd1);
            if (chk_data) check("rdata", RDATA, exp[beat]);
            check("rlast", 64'(RLAST), 64'(beat == len));
            check("rresp", 64'(RRESP), 64'(exp_resp));
            tick();
            cyc++;
            if (rr) beat++;
        end
        RREADY = 1'b0;
        check("r_beats_done", 64'(beat), 64'(len + 1));
        check("rvalid_drop", 64'(RVALID), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, 64'(AWREADY), 64'd0);
        check({tag, "_wready"},  64'(WREADY),  64'd0);
        check({tag, "_bvalid"},  64'(BVALID),  64'd0);
        check({tag, "_bresp"},   64'(BRESP),   64'd0);
        check({tag, "_arready"}, 64'(ARREADY), 64'd0);
        check({tag, "_rvalid"},  64'(RVALID),  64'd0);
        check({tag, "_rlast"},   64'(RLAST),   64'd0);
        check({tag, "_rdata"},   RDATA,        64'd0);
        check({tag, "_rresp"},   64'(RRESP),   64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int to, sw;
        sys_rst_n = 1'b0;
        AWADDR = '0; AWVALID = 0; AWLEN = '0; AWSIZE = 3'd3; AWBURST = 2'b01;
        WDATA = '0; WVALID = 0; WLAST = 0; WSTRB = '0; BREADY = 0;
        ARADDR = '0; ARVALID = 0; ARLEN = '0; ARSIZE = 3'd3; ARBURST = 2'b01; RREADY = 0;
        for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = 64'hx;
        #1;
        check_all_zero("reset");
        #21;
        sys_rst_n = 1'b1;
        tick();

        // Single 8-beat write then read-back with timing checks
        for (int i = 0; i < 8; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
        axi_write(0, 7, 7, AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b1);
        axi_read(0, 7, AXI_BURST_INCR, 0, AXI_RESP_OKAY, 1'b1);

        // Byte strobes on byte address 0x40 (word 8)
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        axi_write(8, 0, 0, AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0);
        wd[0] = 64'h0; ws[0] = 8'h0F;
        axi_write(8, 0, 0, AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0);
        axi_read(8, 0, AXI_BURST_INCR, 0, AXI_RESP_OKAY, 1'b1);

        // Fill all words, then random strobes, then stalled and random reads
        for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        axi_write(0, 15, 15, AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0);
        for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
        sw = $urandom_range(0, 15);
        axi_write(sw, 15, 15, AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0);
        axi_read($urandom_range(0, 15), 15, AXI_BURST_INCR, 1, AXI_RESP_OKAY, 1'b1);
        axi_read($urandom_range(0, 15), 15, AXI_BURST_INCR, 2, AXI_RESP_OKAY, 1'b1);

        // Protocol errors: early WLAST, missing WLAST, bad size, WRAP read
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        axi_write(2, 3, 1, AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_SLVERR, 1'b0);
        axi_write(5, 1, NO_LAST, AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_SLVERR, 1'b0);
        axi_write(9, 0, 0, 3'd2, AXI_BURST_INCR, AXI_RESP_SLVERR, 1'b0);
        axi_read(0, 15, AXI_BURST_INCR, 0, AXI_RESP_OKAY, 1'b1);
        axi_read(4, 3, 2'b10, 2, AXI_RESP_SLVERR, 1'b0);

        // Wrapping write at word 12 concurrent with a read of words 0..3
        for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        fork
            axi_write(12, 7, 7, AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0);
            axi_read(0, 3, AXI_BURST_INCR, 0, AXI_RESP_OKAY, 1'b1);
        join
        axi_read(12, 7, AXI_BURST_INCR, 2, AXI_RESP_OKAY, 1'b1);

        // Reset in the middle of an 8-beat write
        for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        AWADDR = 32'(4 * 8); AWLEN = 8'd7; AWSIZE = AXI_SIZE_8B; AWBURST = AXI_BURST_INCR;
        AWVALID = 1'b1;
        to = 0;
        while (!AWREADY && to < 20) begin tick(); to++; end
        check("rst_aw_ready", 64'(AWREADY), 64'd1);
        tick();
        AWVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            WDATA = wd[i]; WSTRB = ws[i]; WLAST = 1'b0; WVALID = 1'b1;
            check("rst_w_ready", 64'(WREADY), 64'd1);
            tick();
            model_write(4 + i, wd[i], ws[i]);
        end
        WDATA = wd[3]; WVALID = 1'b1;
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("midburst_reset");
        WVALID = 1'b0;
        tick(); tick();
        sys_rst_n = 1'b1;
        to = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (BVALID) to++;
        end
        check("no_b_after_reset", 64'(to), 64'd0);
        axi_read(4, 2, AXI_BURST_INCR, 0, AXI_RESP_OKAY, 1'b1);
        for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
        axi_write(4, 7, 7, AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0);
        axi_read(4, 7, AXI_BURST_INCR, 2, AXI_RESP_OKAY, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_frame_slave.md
Name: axi4_frame_slave

Overview:
- AXI4 slave (responder) backed by an internal memory. It stands in for the Zynq HP0/HP1 DDR path, so the camera-side AXI4 writer and the HDMI-side AXI4 reader can be run closed-loop on the frame buffer, both in simulation and in a PL-only build.
- Independent write (AW/W/B) and read (AR/R) channel engines share one dual-port word memory.
- It supports INCR bursts with 64-bit beats.

Parameters:
- ADDR_W, 32, width of AWADDR/ARADDR.
- DATA_W, 64, beat width; fixed at 64 (AxSIZE = 3).
- MEM_WORDS, 65536, depth in 64-bit words; power of two. Byte address bits [3+log2(MEM_WORDS)-1:3] index the memory; the upper bits are ignored, so addresses wrap.
- RD_LATENCY, 2, extra idle cycles between the AR handshake and the first RVALID (range 0..15).

Ports:
- clk_100Mhz, input, 1, AXI clock; all logic on the rising edge.
- sys_rst_n, input, 1, asynchronous, active-low reset.
- AWADDR, input, ADDR_W, burst start byte address.
- AWVALID, input, 1, write address valid.
- AWREADY, output, 1, write address accept.
- AWLEN, input, 8, beats minus 1.
- AWSIZE, input, 3, must be 3.
- AWBURST, input, 2, must be 2'b01 (INCR).
- WDATA, input, 64, write beat.
- WVALID, input, 1, write beat valid.
- WREADY, output, 1, write beat accept.
- WLAST, input, 1, last write beat.
- WSTRB, input, 8, byte enables.
- BVALID, output, 1, write response valid.
- BREADY, input, 1, write response accept.
- BRESP, output, 2, 2'b00 OKAY, 2'b10 SLVERR.
- ARADDR, input, ADDR_W, read burst start byte address.
- ARVALID, input, 1, read address valid.
- ARREADY, output, 1, read address accept.
- ARLEN, input, 8, beats minus 1.
- ARSIZE, input, 3, must be 3.
- ARBURST, input, 2, must be INCR.
- RDATA, output, 64, read beat.
- RVALID, output, 1, read beat valid.
- RREADY, input, 1, read beat accept.
- RLAST, output, 1, last read beat.
- RRESP, output, 2, read response.

Behaviour:
- Reset (sys_rst_n = 0, asynchronous): both FSMs go to IDLE and every output is driven to 0 (AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RLAST, RDATA, RRESP). Memory contents are not cleared. Reset mid-burst abandons the burst; no B or R is issued for it.
- Write FSM, W_IDLE:
  - AWREADY = 1.
  - On AWVALID & AWREADY: latch the word address and AWLEN; set the err flag if AWSIZE != 3 or AWBURST != 2'b01; clear the beat counter; go to W_DATA.
- Write FSM, W_DATA:
  - AWREADY = 0, WREADY = 1.
  - Each WVALID & WREADY writes WDATA byte-wise under WSTRB to mem[addr], then addr increments modulo MEM_WORDS and the beat counter increments.
  - WLAST asserted with counter != AWLEN, or counter == AWLEN without WLAST: set err.
  - The burst ends on the WLAST beat. If WLAST never arrives, it ends after beat AWLEN+1 and later beats wait in the next W_IDLE with WREADY = 0.
  - Go to W_RESP.
- Write FSM, W_RESP:
  - WREADY = 0, BVALID = 1, BRESP = err ? 2'b10 : 2'b00.
  - Hold until BREADY, then go to W_IDLE.
  - A new AW is accepted in the cycle after the B handshake at the earliest.
- Write errors: when err is set, beats are still accepted and written; the violation is reported only through BRESP.
- Read FSM, R_IDLE:
  - ARREADY = 1.
  - On handshake: latch addr, len and err (same checks as the write side); load the wait counter with RD_LATENCY; go to R_WAIT.
- Read FSM, R_WAIT:
  - ARREADY = 0.
  - Count down. When the count reaches 0, issue the first memory read (registered, 1 cycle) and go to R_DATA.
  - Required timing: AR handshake at cycle N gives first RVALID at cycle N+2+RD_LATENCY.
- Read FSM, R_DATA:
  - RVALID = 1. RDATA, RLAST and RRESP stay stable while RVALID & !RREADY.
  - On RVALID & RREADY, the next beat is presented in the following cycle with no bubble. This needs a prefetch/skid register holding one word ahead, which gives full throughput (one beat per cycle while RREADY = 1).
  - RLAST = 1 on beat index len.
  - After the last handshake: RVALID = 0 and go to R_IDLE.
  - RRESP = err ? 2'b10 : 2'b00 on every beat.
- Same-cycle read and write to the same word: the read returns the old data (read-first). Write data is visible to a read issued one or more cycles after the write beat.
- Address wrap: a burst crossing the top of memory continues at word 0. The 4 KB AXI boundary is not checked.
- The two channels are fully concurrent. There are no ID signals, at most one outstanding transaction per channel, and responses are in order.

Decomposition:
- Shared package axi4_frame_pkg holds:
  - constants AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10, AXI_BURST_INCR = 2'b01, AXI_SIZE_8B = 3'd3;
  - the write and read FSM state encodings.
- One sub-module: axi4_frame_mem, a true dual-port 64-bit RAM with an 8-bit byte-write port (A) and a registered, read-first read port (B). It must be BRAM-inferable.

Test Plan:
- Single write: AWADDR = 0x0, AWLEN = 7, beats 0x1..0x8, WSTRB = 0xFF, BREADY = 1 -> 8 beats accepted back-to-back, BVALID one cycle after the WLAST beat, BRESP = 0. A following AR at 0x0 with ARLEN = 7 and RD_LATENCY = 2 -> first RVALID at N+4, data 0x1..0x8, RLAST on beat 7 only.
- Byte strobes: write 0xFFFF_FFFF_FFFF_FFFF to 0x40, then 0x0 with WSTRB = 0x0F -> read back 0xFFFF_FFFF_0000_0000.
- RREADY backpressure: RREADY toggles 1,0,0,1 during a 16-beat read -> RDATA and RLAST hold during stalls, all 16 words in order, no duplicates or losses.
- Protocol error: AWLEN = 3 with WLAST on beat 1 -> BRESP = 2'b10. ARBURST = 2'b10 (WRAP) -> RRESP = 2'b10 on all beats.
- Wrap and concurrency: with MEM_WORDS = 16, an 8-beat write at word 12 lands in words 12..15 then 0..3. A simultaneous read at word 0 in the same cycle returns the old contents for that word.
- Reset mid-burst: drop sys_rst_n on beat 3 of 8 -> all outputs are 0 asynchronously, no BVALID afterwards. A subsequent write/read completes normally.
